rotate_req_sequencer: RTL and testbench

Upstream front-end for the 8-bit combinational right rotator (`rotate_right`: ports a, amt, y). It accepts rotate requests over a valid/ready interface and buffers them in a small FIFO. Left-rotate requests are converted to the equivalent right amount. The block drives the rotator's a/amt from a register, captures y into an output register, and presents results downstream with valid/ready backpressure.

---
 rtl/rotate_req_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_rotate_req_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_req_sequencer.sv
// ---------------------------------------------------------------------------
// rotate_req_sequencer
//
// Front-end for an external combinational right rotator. Rotate requests
// are accepted over a valid/ready interface into a small FIFO. Left rotates
// are turned into the equivalent right amount as they are pushed. The FIFO
// head is loaded into the S1 register (rot_a/rot_amt), which feeds the
// rotator. The rotator result rot_y is captured into the S2 register
// (out_data), which is presented downstream with valid/ready backpressure.
//
// Handshake semantics (both sides): a transfer happens on a rising clk
// edge where valid and ready are both high. in_ready is a function of FIFO
// occupancy only. out_valid never depends on out_ready.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request can be accepted (FIFO not full)
//   in_data    in   [DATA_W] operand to rotate
//   in_amt     in   [AMT_W]  rotate amount
//   in_left    in   1 = rotate left, 0 = rotate right
//   rot_a      out  [DATA_W] registered operand to the rotator
//   rot_amt    out  [AMT_W]  registered right-rotate amount to the rotator
//   rot_y      in   [DATA_W] combinational result from the rotator
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   out_data   out  [DATA_W] registered rotated result
//   busy       out  any FIFO entry, S1 or S2 occupied
// ---------------------------------------------------------------------------
module rotate_req_sequencer #(
    parameter int DATA_W     = 8,
    parameter int AMT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_left,
    output logic [DATA_W-1:0] rot_a,
    output logic [AMT_W-1:0]  rot_amt,
    input  logic [DATA_W-1:0] rot_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + AMT_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // FIFO storage: each entry is {right_amount, operand}
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // S1: operand/amount presented to the rotator
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] rot_a_q, rot_a_d;
    logic [AMT_W-1:0]  rot_amt_q, rot_amt_d;

    // S2: captured rotator result
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic             push;
    logic             pop;
    logic             s2_adv;
    logic             s1_load;
    logic [AMT_W-1:0] amt_conv;
    logic [ENT_W-1:0] head;

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    // in_ready looks only at the registered count, so a full FIFO refuses a
    // request even in a cycle where the head is popped.
    assign in_ready = (count_q != CNT_FULL);
    assign push     = in_valid & in_ready;

    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    // No bypass: S1 only ever loads from an entry already stored in the FIFO.
    assign s1_load  = (count_q != '0) & (~s1_valid_q | s2_adv);
    assign pop      = s1_load;

    // Left by k equals right by (2^AMT_W - k) mod 2^AMT_W; left 0 stays 0.
    assign amt_conv = in_left ? (AMT_W'(0) - in_amt) : in_amt;

    assign head     = mem_q[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        rot_a_d    = rot_a_q;
        rot_amt_d  = rot_amt_q;

        // S1 registers only change on a load; otherwise they hold, even when
        // S1 has emptied, so the rotator input stays quiet.
        if (s1_load) begin
            s1_valid_d = 1'b1;
            rot_a_d    = head[DATA_W-1:0];
            rot_amt_d  = head[ENT_W-1:DATA_W];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            out_data_d = rot_y;
        end else if (s2_valid_q & out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {amt_conv, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            rot_a_q    <= '0;
            rot_amt_q  <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            rot_a_q    <= rot_a_d;
            rot_amt_q  <= rot_amt_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rot_a     = rot_a_q;
    assign rot_amt   = rot_amt_q;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (count_q != '0) | s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_rotate_req_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for rotate_req_sequencer. The external rotator is modelled by a
// continuous assign; the expected results come from a separate bit-index
// reference rotate and a FIFO-ordered expected queue.
// ---------------------------------------------------------------------------
module tb_rotate_req_sequencer;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_left;
    logic [7:0] rot_a;
    logic [2:0] rot_amt;
    logic [7:0] rot_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int total;
    int bad;

    logic [7:0] exp_q[$];

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    rotate_req_sequencer #(
        .DATA_W     (8),
        .AMT_W      (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_left   (in_left),
        .rot_a     (rot_a),
        .rot_amt   (rot_amt),
        .rot_y     (rot_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Stand-in for the external combinational rotator.
    logic [15:0] rot_dbl;
    assign rot_dbl = {rot_a, rot_a} >> rot_amt;
    assign rot_y   = rot_dbl[7:0];

    // ------------------------------------------------------------ reference
    function automatic logic [7:0] ref_rotate(input logic [7:0] a, input logic [2:0] amt,
                                               input logic left);
        int r;
        logic [7:0] y;
        r = left ? int'(amt) : (8 - int'(amt)) % 8;  // left shift distance
        for (int i = 0; i < 8; i++) begin
            y[(i + r) % 8] = a[i];
        end
        return y;
    endfunction

    // Scoreboard: record accepted requests, compare every accepted result.
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_rotate(in_data, in_amt, in_left));
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_extra: got out_data=%02h, required no output", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL scoreboard_data: got %02h, required %02h", out_data, e);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [7:0] d, input logic [2:0] a,
                             input logic l);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_left  = l;
    endtask

    task automatic drain(input string name);
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: busy=%0b pending=%0d, required busy=0 pending=0",
                     name, busy, exp_q.size());
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        reset_n = 1'b0;
        drive_req(1'b0, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        repeat (2) tick();
        total++;
        if ({out_valid, busy, in_ready, rot_a, rot_amt, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h00}) begin
            bad++;
            $display("FAIL reset_state: got ov=%0b busy=%0b ir=%0b a=%02h amt=%0d d=%02h, required 0 0 1 00 0 00",
                     out_valid, busy, in_ready, rot_a, rot_amt, out_data);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [7:0] exp_seq [3];
        exp_seq[0] = 8'b11100100;
        exp_seq[1] = 8'b00111001;
        exp_seq[2] = 8'b01001110;
        out_ready = 1'b1;
        drive_req(1'b1, 8'b10010011, 3'd2, 1'b0);
        tick();                                   // edge k: push
        drive_req(1'b1, 8'b10010011, 3'd4, 1'b0);
        tick();                                   // edge k+1
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_latency_early: got out_valid=%0b, required 0", out_valid);
        end
        drive_req(1'b1, 8'b10010011, 3'd6, 1'b0);
        tick();                                   // edge k+2
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                bad++;
                $display("FAIL seq_result%0d: got ov=%0b d=%08b, required ov=1 d=%08b",
                         i, out_valid, out_data, exp_seq[i]);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL seq_idle: got out_valid=%0b, required 0", out_valid);
        end
        drain("seq");
    endtask

    task automatic test_left();
        logic [2:0] amts [2];
        logic [7:0] res  [2];
        logic [2:0] want_amt [2];
        amts[0] = 3'd2; want_amt[0] = 3'd6; res[0] = 8'b01001110;
        amts[1] = 3'd0; want_amt[1] = 3'd0; res[1] = 8'b10010011;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_req(1'b1, 8'b10010011, amts[i], 1'b1);
            tick();
            in_valid = 1'b0;
            tick();
            total++;
            if (rot_amt !== want_amt[i] || rot_a !== 8'b10010011) begin
                bad++;
                $display("FAIL left_amt%0d: got amt=%0d a=%02h, required amt=%0d a=93",
                         i, rot_amt, rot_a, want_amt[i]);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== res[i]) begin
                bad++;
                $display("FAIL left_data%0d: got ov=%0b d=%08b, required ov=1 d=%08b",
                         i, out_valid, out_data, res[i]);
            end
        end
        drain("left");
    endtask

    task automatic fill_stalled(output int accepted);
        accepted = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int accepted;
        logic [7:0] held;
        fill_stalled(accepted);
        total++;
        if (accepted != 6 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_capacity: got accepted=%0d in_ready=%0b, required 6 and 0",
                     accepted, in_ready);
        end
        held = out_data;
        repeat (3) tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
            bad++;
            $display("FAIL bp_hold: got ov=%0b d=%02h, required ov=1 d=%02h", out_valid, out_data, held);
        end
        drain("bp");
    endtask

    task automatic test_full_pop();
        int accepted;
        fill_stalled(accepted);
        drive_req(1'b1, 8'hA5, 3'd1, 1'b0);
        out_ready = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_refuse: got in_ready=%0b, required 0", in_ready);
        end
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL fullpop_after: got in_ready=%0b, required 1", in_ready);
        end
        in_valid = 1'b0;
        drain("fullpop");
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 8'($urandom_range(1, 255)), 3'($urandom_range(1, 7)), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_preload: got busy=%0b ov=%0b, required 1 1", busy, out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        total++;
        if ({out_valid, busy, in_ready, rot_a, out_data} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00}) begin
            bad++;
            $display("FAIL rstmid_async: got ov=%0b busy=%0b ir=%0b a=%02h d=%02h, required 0 0 1 00 00",
                     out_valid, busy, in_ready, rot_a, out_data);
        end
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rstmid_stale: got %0d active cycles after release, required 0", seen);
        end
    endtask

    task automatic test_wrap();
        int pushed;
        int cyc;
        pushed = 0;
        cyc = 0;
        while (pushed < 12 && cyc < 300) begin
            drive_req(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) pushed++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (pushed != 12) begin
            bad++;
            $display("FAIL wrap_push_budget: got %0d pushes, required 12", pushed);
        end
        drain("wrap");
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_sequential();
        test_left();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
